// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: opcodes,
// error codes, controller states and a small decode helper.
package calc_pkg;

  localparam int OPND_W = 16;
  localparam int RES_W  = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ALU     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // A divide by zero is caught here so the ALU is never launched for it.
  function automatic logic is_div_by_zero(input logic [1:0] op,
                                          input logic [OPND_W-1:0] b);
    return (opcode_e'(op) == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/calc_timeout_cnt.sv
// Watchdog counter for an outstanding ALU operation. Loads zero, counts up
// while enabled and saturates at TIMEOUT-1; expire flags the last allowed
// wait cycle.
module calc_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise step while enabled and below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: takes operands from the number-entry block, launches
// the shared multicycle ALU, waits for completion with a timeout, and holds
// the result or an error code until the user acknowledges it.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [OPND_W-1:0] op_a,
  input  logic [OPND_W-1:0] op_b,
  input  logic [1:0]        opcode,
  input  logic              ack,
  input  logic              clear,
  output logic              alu_start,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic              alu_done,
  input  logic              alu_err,
  input  logic [RES_W-1:0]  alu_result,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic              busy,
  output logic [1:0]        err_code
);

  state_e            state_q,    state_d;
  logic [OPND_W-1:0] alu_a_q,    alu_a_d;
  logic [OPND_W-1:0] alu_b_q,    alu_b_d;
  logic [1:0]        alu_op_q,   alu_op_d;
  logic [RES_W-1:0]  result_q,   result_d;
  logic [1:0]        err_code_q, err_code_d;

  logic cnt_load;
  logic cnt_en;
  logic cnt_expire;

  calc_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .enable (cnt_en),
    .expire (cnt_expire)
  );

  // Next-state and register updates; clear overrides every other input.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    cnt_load   = 1'b0;
    cnt_en     = (state_q == ST_WAIT);

    if (clear) begin
      state_d    = ST_IDLE;
      result_d   = '0;
      err_code_d = ERR_NONE;
      cnt_load   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            alu_a_d  = op_a;
            alu_b_d  = op_b;
            alu_op_d = opcode;
            if (is_div_by_zero(opcode, op_b)) begin
              state_d    = ST_ERR;
              err_code_d = ERR_DIV0;
            end else begin
              state_d = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          // A completion in the final allowed cycle beats the timeout.
          if (alu_done) begin
            if (alu_err) begin
              state_d    = ST_ERR;
              err_code_d = ERR_ALU;
            end else begin
              state_d  = ST_DONE;
              result_d = alu_result;
            end
          end else if (cnt_expire) begin
            state_d    = ST_ERR;
            err_code_d = ERR_TIMEOUT;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state_d = ST_IDLE;
          end
        end
        ST_ERR: begin
          if (ack) begin
            state_d    = ST_IDLE;
            err_code_d = ERR_NONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 2'b00;
      result_q   <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
    end
  end

  assign alu_start    = (state_q == ST_ISSUE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer with TIMEOUT=8. The bench plays the ALU and the
// user; expectations come from a transaction-level view of each operation.
module tb_calc_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  opcode;
  logic        ack;
  logic        clear;
  logic        alu_start;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_done;
  logic        alu_err;
  logic [31:0] alu_result;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic [1:0]  err_code;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_result = 32'd0;

  calc_sequencer #(
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .opcode       (opcode),
    .ack          (ack),
    .clear        (clear),
    .alu_start    (alu_start),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_done     (alu_done),
    .alu_err      (alu_err),
    .alu_result   (alu_result),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".alu_start"}, {31'd0, alu_start}, 32'd0);
    check_eq({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, ".result_valid"}, {31'd0, result_valid}, 32'd0);
    check_eq({tag, ".err_code"}, {30'd0, err_code}, 32'd0);
    check_eq({tag, ".result"}, result, exp_result);
  endtask

  // Present one operand set for a single cycle; returns at the negedge of
  // the cycle after op_valid was sampled.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    @(negedge clk);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    opcode   = op;
    @(negedge clk);
    op_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    opcode   = 2'($urandom);
  endtask

  // One full operation. k is the cycle after alu_start on which the ALU
  // answers; k > TO means it never answers in time.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input int k, input bit aerr, input logic [31:0] ares,
                        input bit noise, input bit do_ack);
    logic       exp_rv;
    logic [1:0] exp_ec;
    int         hold;
    launch(a, b, op);
    check_eq("latch.alu_a", {16'd0, alu_a}, {16'd0, a});
    check_eq("latch.alu_b", {16'd0, alu_b}, {16'd0, b});
    check_eq("latch.alu_op", {30'd0, alu_op}, {30'd0, op});
    if (op == 2'b11 && b == 16'd0) begin
      check_eq("div0.alu_start", {31'd0, alu_start}, 32'd0);
      exp_rv = 1'b0;
      exp_ec = 2'b01;
    end else begin
      check_eq("issue.alu_start", {31'd0, alu_start}, 32'd1);
      check_eq("issue.busy", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= TO; i++) begin
        @(negedge clk);
        op_valid = 1'b0;
        ack      = 1'b0;
        check_eq("wait.alu_start", {31'd0, alu_start}, 32'd0);
        check_eq("wait.busy", {31'd0, busy}, 32'd1);
        check_eq("wait.alu_a", {16'd0, alu_a}, {16'd0, a});
        check_eq("wait.err_code", {30'd0, err_code}, 32'd0);
        check_eq("wait.result_valid", {31'd0, result_valid}, 32'd0);
        if (noise) begin
          op_valid = 1'($urandom_range(0, 1));
          op_a     = 16'd99;
          ack      = 1'($urandom_range(0, 1));
        end
        if (i == k) begin
          alu_done   = 1'b1;
          alu_err    = aerr;
          alu_result = ares;
          break;
        end
      end
      @(negedge clk);
      alu_done = 1'b0;
      alu_err  = 1'b0;
      op_valid = 1'b0;
      ack      = 1'b0;
      if (k <= TO) begin
        if (aerr) begin
          exp_rv = 1'b0;
          exp_ec = 2'b11;
        end else begin
          exp_rv     = 1'b1;
          exp_ec     = 2'b00;
          exp_result = ares;
        end
      end else begin
        exp_rv = 1'b0;
        exp_ec = 2'b10;
      end
    end
    check_eq("end.result_valid", {31'd0, result_valid}, {31'd0, exp_rv});
    check_eq("end.err_code", {30'd0, err_code}, {30'd0, exp_ec});
    check_eq("end.result", result, exp_result);
    check_eq("end.busy", {31'd0, busy}, 32'd0);
    check_eq("end.alu_start", {31'd0, alu_start}, 32'd0);
    hold = noise ? $urandom_range(0, 2) : 0;
    for (int j = 0; j < hold; j++) begin
      alu_done   = 1'($urandom_range(0, 1));
      alu_err    = 1'($urandom_range(0, 1));
      alu_result = $urandom;
      op_valid   = 1'($urandom_range(0, 1));
      op_a       = 16'($urandom);
      @(negedge clk);
      alu_done = 1'b0;
      alu_err  = 1'b0;
      op_valid = 1'b0;
      check_eq("hold.result_valid", {31'd0, result_valid}, {31'd0, exp_rv});
      check_eq("hold.err_code", {30'd0, err_code}, {30'd0, exp_ec});
      check_eq("hold.result", result, exp_result);
      check_eq("hold.alu_a", {16'd0, alu_a}, {16'd0, a});
    end
    if (do_ack) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check_idle("ack");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    int          k;
    bit          aerr;

    rst        = 1'b1;
    op_valid   = 1'b0;
    op_a       = 16'd0;
    op_b       = 16'd0;
    opcode     = 2'b00;
    ack        = 1'b0;
    clear      = 1'b0;
    alu_done   = 1'b0;
    alu_err    = 1'b0;
    alu_result = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    check_eq("reset.alu_a", {16'd0, alu_a}, 32'd0);
    check_eq("reset.alu_b", {16'd0, alu_b}, 32'd0);
    check_eq("reset.alu_op", {30'd0, alu_op}, 32'd0);

    // 12 * 5 with the ALU answering on the 7th wait cycle.
    run_op(16'd12, 16'd5, 2'b10, 7, 1'b0, 32'd60, 1'b0, 1'b1);

    // Divide by zero never reaches the ALU.
    run_op(16'd40, 16'd0, 2'b11, 1, 1'b0, 32'd0, 1'b0, 1'b1);

    // Timeout with no response, then a response on the last allowed cycle.
    run_op(16'd3, 16'd4, 2'b00, TO + 1, 1'b0, 32'd0, 1'b0, 1'b1);
    run_op(16'd3, 16'd4, 2'b00, TO, 1'b0, 32'd7, 1'b0, 1'b1);

    // ALU reports an error.
    run_op(16'd9, 16'd2, 2'b01, 3, 1'b1, 32'hDEAD, 1'b0, 1'b1);

    // Stray op_valid (op_a=99) and ack during WAIT are ignored.
    run_op(16'd500, 16'd6, 2'b10, 5, 1'b0, 32'd3000, 1'b1, 1'b1);

    // Clear coincident with alu_done in WAIT.
    launch(16'd21, 16'd2, 2'b00);
    repeat (3) @(negedge clk);
    alu_done   = 1'b1;
    alu_result = 32'd77;
    clear      = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    clear    = 1'b0;
    exp_result = 32'd0;
    check_idle("clear_wait");
    @(negedge clk);
    check_idle("clear_wait2");

    // Reset in WAIT; a late alu_done is ignored.
    run_op(16'd8, 16'd8, 2'b00, 2, 1'b0, 32'd16, 1'b0, 1'b1);
    launch(16'd1, 16'd1, 2'b01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    exp_result = 32'd0;
    alu_done   = 1'b1;
    alu_result = 32'd555;
    @(negedge clk);
    alu_done = 1'b0;
    check_idle("rst_wait");

    // Reset in DONE with result 60; the following ack does nothing.
    run_op(16'd12, 16'd5, 2'b10, 7, 1'b0, 32'd60, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    exp_result = 32'd0;
    check_idle("rst_done");
    check_eq("rst_done.alu_a", {16'd0, alu_a}, 32'd0);
    check_eq("rst_done.alu_b", {16'd0, alu_b}, 32'd0);
    check_eq("rst_done.alu_op", {30'd0, alu_op}, 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_idle("rst_done_ack");

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      a    = 16'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      op   = 2'($urandom_range(0, 3));
      k    = $urandom_range(1, TO + 2);
      aerr = ($urandom_range(0, 5) == 0);
      run_op(a, b, op, k, aerr, $urandom, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
